// File: rtl/lcd_timing_driver.sv
// lcd_timing_driver: 800x480 RGB panel timing, pixel request decode and per-frame game tick.
// Requests lead the registered panel outputs by one pclk so renderers get a full cycle.
module lcd_timing_driver #(
    parameter int H_SYNC  = 128,
    parameter int H_BACK  = 88,
    parameter int H_DISP  = 800,
    parameter int H_FRONT = 40,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic [15:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        data_req,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [15:0] lcd_rgb,
    output logic        frame_tick
);
    localparam logic [10:0] H_LAST = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [10:0] V_LAST = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [10:0] X_BEG  = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] X_END  = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] Y_BEG  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] Y_END  = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] HS_END = 11'(H_SYNC);
    localparam logic [10:0] VS_END = 11'(V_SYNC);

    logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        h_wrap;
    logic        hs_q, vs_q, de_q, tick_q;
    logic [15:0] rgb_q;

    always_comb begin
        h_wrap     = h_cnt_q == H_LAST;
        h_cnt_d    = h_wrap ? '0 : h_cnt_q + 11'd1;
        v_cnt_d    = !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST ? '0 : v_cnt_q + 11'd1);
        data_req   = (h_cnt_q >= X_BEG) && (h_cnt_q < X_END) && (v_cnt_q >= Y_BEG) && (v_cnt_q < Y_END);
        pixel_xpos = data_req ? h_cnt_q - X_BEG : '0;
        pixel_ypos = data_req ? v_cnt_q - Y_BEG : '0;
    end

    always_ff @(posedge lcd_pclk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= !(h_cnt_q < HS_END);
            vs_q    <= !(v_cnt_q < VS_END);
            de_q    <= data_req;
            rgb_q   <= data_req ? pixel_data : 16'h0000;
            // first front-porch line: the start of vertical blanking
            tick_q  <= (h_cnt_q == '0) && (v_cnt_q == Y_END);
        end
    end

    assign lcd_hs     = hs_q;
    assign lcd_vs     = vs_q;
    assign lcd_de     = de_q;
    assign lcd_rgb    = rgb_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_lcd_timing_driver.sv
// tb_lcd_timing_driver: directed checks of the default 800x480 timing and a tiny 16x4 panel.
// Sample index s counts negedges with rst_n high; in sample s the counters hold s-1.
module tb_lcd_timing_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] x0, y0, x1, y1;
    logic        rq0, hs0, vs0, de0, tk0, rq1, hs1, vs1, de1, tk1;
    logic [15:0] rgb0, rgb1;
    int          n_tot = 0, n_bad = 0;
    int          s = 0;

    always #5 clk = ~clk;

    lcd_timing_driver d0 (
        .lcd_pclk(clk), .rst_n(rst_n), .pixel_data({5'd0, x0}),
        .pixel_xpos(x0), .pixel_ypos(y0), .data_req(rq0),
        .lcd_hs(hs0), .lcd_vs(vs0), .lcd_de(de0), .lcd_rgb(rgb0), .frame_tick(tk0)
    );

    lcd_timing_driver #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(16), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1)
    ) d1 (
        .lcd_pclk(clk), .rst_n(rst_n), .pixel_data({5'd0, x1}),
        .pixel_xpos(x1), .pixel_ypos(y1), .data_req(rq1),
        .lcd_hs(hs1), .lcd_vs(vs1), .lcd_de(de1), .lcd_rgb(rgb1), .frame_tick(tk1)
    );

    int   hs0_fall, hs0_per, hs0_run, hs0_low, vs0_run, vs0_low;
    int   de0_first, de0_run, de0_runs, de0_badrun, rgb0_bad, col0, tk0_cnt;
    int   hs1_fall, hs1_per, hs1_run, hs1_low, vs1_fall, vs1_per, vs1_run, vs1_low;
    int   de1_first, de1_run, de1_badrun, rgb1_bad, col1, de1_tot, de1_mark, de1_frame;
    int   tk1_cnt, tk1_first, tk1_last, tk1_per, tk1_wide;
    logic hs0_p, vs0_p, de0_p, hs1_p, vs1_p, de1_p, tk1_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            s = 0;
            hs0_fall = 0; hs0_per = 0; hs0_run = 0; hs0_low = 0; vs0_run = 0; vs0_low = 0;
            de0_first = 0; de0_run = 0; de0_runs = 0; de0_badrun = 0; rgb0_bad = 0; col0 = 0; tk0_cnt = 0;
            hs1_fall = 0; hs1_per = 0; hs1_run = 0; hs1_low = 0; vs1_fall = 0; vs1_per = 0; vs1_run = 0; vs1_low = 0;
            de1_first = 0; de1_run = 0; de1_badrun = 0; rgb1_bad = 0; col1 = 0; de1_tot = 0; de1_mark = 0; de1_frame = 0;
            tk1_cnt = 0; tk1_first = 0; tk1_last = 0; tk1_per = 0; tk1_wide = 0;
        end else begin
            s++;
            if (!hs0 && hs0_p) begin
                if (hs0_fall != 0) hs0_per = s - hs0_fall;
                hs0_fall = s;
            end
            if (hs0 && !hs0_p) hs0_low = hs0_run;
            hs0_run = hs0 ? 0 : hs0_run + 1;
            if (vs0 && !vs0_p) vs0_low = vs0_run;
            vs0_run = vs0 ? 0 : vs0_run + 1;
            if (de0 && !de0_p && de0_first == 0) de0_first = s;
            if (!de0 && de0_p) begin
                de0_runs++;
                if (de0_run != 800) de0_badrun++;
            end
            de0_run = de0 ? de0_run + 1 : 0;
            if (de0) begin
                if (rgb0 != 16'(col0)) rgb0_bad++;
                col0++;
            end else begin
                col0 = 0;
                if (rgb0 != 16'h0) rgb0_bad++;
            end
            if (tk0) tk0_cnt++;
            if (!hs1 && hs1_p) begin
                if (hs1_fall != 0) hs1_per = s - hs1_fall;
                hs1_fall = s;
            end
            if (hs1 && !hs1_p) hs1_low = hs1_run;
            hs1_run = hs1 ? 0 : hs1_run + 1;
            if (!vs1 && vs1_p) begin
                if (vs1_fall != 0) vs1_per = s - vs1_fall;
                vs1_fall = s;
            end
            if (vs1 && !vs1_p) vs1_low = vs1_run;
            vs1_run = vs1 ? 0 : vs1_run + 1;
            if (de1 && !de1_p && de1_first == 0) de1_first = s;
            if (!de1 && de1_p && de1_run != 16) de1_badrun++;
            de1_run = de1 ? de1_run + 1 : 0;
            if (de1) begin
                if (rgb1 != 16'(col1)) rgb1_bad++;
                col1++;
                de1_tot++;
            end else begin
                col1 = 0;
                if (rgb1 != 16'h0) rgb1_bad++;
            end
            if (tk1 && tk1_p) tk1_wide++;
            if (tk1 && !tk1_p) begin
                tk1_cnt++;
                if (tk1_first == 0) tk1_first = s;
                if (tk1_last != 0) tk1_per = s - tk1_last;
                tk1_last = s;
                de1_frame = de1_tot - de1_mark;
                de1_mark = de1_tot;
            end
        end
        hs0_p = hs0; vs0_p = vs0; de0_p = de0;
        hs1_p = hs1; vs1_p = vs1; de1_p = de1; tk1_p = tk1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_s(input int t);
        while (s < t) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d0"}, {hs0, vs0, de0, tk0, rq0, rgb0, x0, y0}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 11'd0, 11'd0});
        check({tag, "_d1"}, {hs1, vs1, de1, tk1, rq1, rgb1, x1, y1}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 11'd0, 11'd0});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        // tiny panel: HA=4, VA=2, line 22, frame 154
        wait_s(47); check("d1_req_before", rq1, 0);
        wait_s(48); check("d1_req_first", {rq1, x1, y1}, {1'b1, 11'd0, 11'd0});
        wait_s(63); check("d1_req_last", {rq1, x1, y1}, {1'b1, 11'd15, 11'd0});
        wait_s(64); check("d1_req_after", rq1, 0);
        wait_s(71); check("d1_req_row1", {rq1, x1, y1}, {1'b1, 11'd1, 11'd1});
        // default panel: first request at h=215, v=35
        wait_s(37175); check("d0_req_before", rq0, 0);
        wait_s(37176); check("d0_req_first", {rq0, x0, y0}, {1'b1, 11'd0, 11'd0});
        wait_s(37975); check("d0_req_last", {rq0, x0, y0}, {1'b1, 11'd799, 11'd0});
        wait_s(37976); check("d0_req_after", rq0, 0);
        wait_s(38232); check("d0_req_row1", {rq0, x0, y0}, {1'b1, 11'd0, 11'd1});
        wait_s(40000);
        check("d0_hs_period", hs0_per, 1056);
        check("d0_hs_low", hs0_low, 128);
        check("d0_vs_low", vs0_low, 2112);
        check("d0_de_first", de0_first, 35 * 1056 + 216 + 1);
        check("d0_de_lines", de0_runs, 2);
        check("d0_de_badrun", de0_badrun, 0);
        check("d0_rgb_bad", rgb0_bad, 0);
        check("d0_no_tick", tk0_cnt, 0);
        check("d0_de_midline", de0, 1);
        check("d1_hs_period", hs1_per, 22);
        check("d1_hs_low", hs1_low, 2);
        check("d1_vs_period", vs1_per, 154);
        check("d1_vs_low", vs1_low, 22);
        check("d1_de_first", de1_first, 49);
        check("d1_de_badrun", de1_badrun, 0);
        check("d1_de_per_frame", de1_frame, 64);
        check("d1_rgb_bad", rgb1_bad, 0);
        check("d1_tick_first", tk1_first, 134);
        check("d1_tick_period", tk1_per, 154);
        check("d1_tick_wide", tk1_wide, 0);
        check("d1_tick_count", tk1_cnt, 259);
        // abort mid-line of the default panel, hold 3 cycles
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        wait_s(49); check("d1_rel_de", de1, 1);
        wait_s(37178);
        check("d1_rel_de_first", de1_first, 49);
        check("d0_rel_de_first", de0_first, 35 * 1056 + 216 + 1);
        check("d0_rel_hs_period", hs0_per, 1056);
        check("d0_rel_rgb_bad", rgb0_bad, 0);
        check("d1_rel_tick_first", tk1_first, 134);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_timing_driver.md
Name: lcd_timing_driver

Overview:
- Panel-side timing generator for the 800x480 RGB LCD.
- Produces the pixel_xpos/pixel_ypos scan coordinates that the sprite and ground renderers consume, and samples their composed colour back as pixel_data.
- Drives panel sync, data-enable and RGB, and issues a once-per-frame game tick.
- Runs entirely on lcd_pclk.

Parameters:
H_SYNC, 128, hsync pulse width in pclk cycles
H_BACK, 88, horizontal back porch
H_DISP, 800, active pixels per line
H_FRONT, 40, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_DISP, 480, active lines per frame
V_FRONT, 10, vertical front porch

Ports:
lcd_pclk  input  1  pixel clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of lcd_pclk
pixel_data  input  16  RGB565 colour for the current pixel_xpos/pixel_ypos; combinational from the coordinates
pixel_xpos  output  11  active-area column being requested, 0..H_DISP-1
pixel_ypos  output  11  active-area row being requested, 0..V_DISP-1
data_req  output  1  high when pixel_xpos/pixel_ypos are valid requests
lcd_hs  output  1  horizontal sync, active low
lcd_vs  output  1  vertical sync, active low
lcd_de  output  1  data enable, active high
lcd_rgb  output  16  pixel colour to the panel
frame_tick  output  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT (1056).
  - V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT (525).
  - HA = H_SYNC + H_BACK (216).
  - VA = V_SYNC + V_BACK (35).
- Counters: h_cnt and v_cnt, 11 bits each.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the cycle h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
  - No other wrap points; values never exceed TOTAL-1.
- Request decode (combinational from the counters, zero latency):
  - data_req = (h_cnt in [HA-1, HA+H_DISP-1)) AND (v_cnt in [VA, VA+V_DISP)).
  - When data_req: pixel_xpos = h_cnt-(HA-1), pixel_ypos = v_cnt-VA. Otherwise both are 0.
  - The request leads the panel by exactly one cycle, covering the renderer's combinational path.
- Panel outputs are registered, one cycle behind the decode of the same counter values:
  - lcd_hs <= NOT(h_cnt < H_SYNC).
  - lcd_vs <= NOT(v_cnt < V_SYNC).
  - lcd_de <= data_req.
  - lcd_rgb <= data_req ? pixel_data : 16'h0000.
  - Result: lcd_de is high exactly on the cycles after h_cnt = HA..HA+H_DISP-1 of the active lines, i.e. 800 cycles per active line.
  - lcd_rgb is 0 whenever lcd_de is 0.
- frame_tick:
  - Registered; high for one cycle, the cycle after (h_cnt == 0 AND v_cnt == VA+V_DISP).
  - That is the start of the first front-porch line; exactly once per frame.
- Line/frame wrap:
  - The last active pixel of line 479 is followed directly by blanking; no extra request.
  - A request never spans a line boundary.
- Reset: the synchronous reset takes priority over counting.
  - Values while rst_n is low: h_cnt = 0, v_cnt = 0, lcd_hs = 1, lcd_vs = 1, lcd_de = 0, lcd_rgb = 0, frame_tick = 0.
  - data_req is 0 (counters at 0), pixel_xpos = 0, pixel_ypos = 0.
  - Reset asserted mid-line or mid-frame aborts immediately on the next edge.
  - Timing restarts from h_cnt = 0, v_cnt = 0 on the first edge with rst_n high.
  - No partial frame_tick is emitted.
- No handshake back-pressure: upstream must supply pixel_data in the same cycle as the request.

Test Plan:
1. Release reset, count cycles between lcd_hs falling edges -> 1056. lcd_hs is low for 128 cycles. Between lcd_vs falling edges -> 554400 cycles, with lcd_vs low for 2112 cycles.
2. First active line -> data_req first rises at h_cnt = 215, v_cnt = 35 with pixel_xpos = 0, pixel_ypos = 0. lcd_de rises the next cycle. Last request has pixel_xpos = 799. lcd_de is high exactly 800 cycles per line and 480 lines per frame.
3. pixel_data tied to {5'd0, pixel_xpos} -> on every lcd_de cycle lcd_rgb equals the column index 0..799 in order. lcd_rgb = 0 outside DE.
4. frame_tick -> exactly one single-cycle pulse per 554400 cycles, one cycle after h_cnt = 0, v_cnt = 515. None between.
5. Assert rst_n low for 3 cycles at v_cnt = 200, h_cnt = 500 -> outputs at reset values on the next edge. After release, first lcd_de occurs 35*1056 + 216 + 1 cycles later, and the frame is complete.
6. Non-default parameters (H_DISP = 16, H_SYNC = 2, H_BACK = 2, H_FRONT = 2, V_DISP = 4, V_SYNC = 1, V_BACK = 1, V_FRONT = 1) -> line period 22 cycles, frame 154 cycles, 16x4 DE cycles per frame.
